// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: word alignment on control tokens, then 10b->8b decode.
// Optional unlock-event counter is built when TMDS_DECODER_ERRCNT_EN is defined.
module tmds_channel_decoder #(
    parameter int SEARCH_TIMEOUT = 1024,
    parameter int LOCK_COUNT     = 16,
    parameter int LOSS_TIMEOUT   = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  tmds_in,
    input  logic        tmds_valid,
    output logic [7:0]  vd,
    output logic [1:0]  cd,
    output logic        vde,
    output logic        out_valid,
    output logic        aligned,
    output logic [3:0]  bit_offset,
    output logic [15:0] err_count
);

    localparam int SW = $clog2(SEARCH_TIMEOUT + 1);
    localparam int TW = $clog2(LOCK_COUNT + 1);
    localparam int LW = $clog2(LOSS_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      off_q, off_d;
    logic [SW-1:0]   srch_q, srch_d;
    logic [TW-1:0]   tok_q, tok_d;
    logic [LW-1:0]   loss_q, loss_d;
    logic [9:0]      prev_q, prev_d;
    logic [7:0]      vd_q, vd_d;
    logic [1:0]      cd_q, cd_d;
    logic            vde_q, vde_d;
    logic            ov_q, ov_d;
    logic            aligned_q, aligned_d;

    logic [19:0]     window_s;
    logic [9:0]      word_s;
    logic [2:0]      tok_info_s;
    logic            is_tok_s;
    logic [1:0]      tok_code_s;

    // Returns {is_token, control_code} for an aligned 10-bit word.
    function automatic logic [2:0] token_lookup(input logic [9:0] w);
        logic [2:0] r;
        case (w)
            10'h354: r = 3'b1_00;
            10'h0AB: r = 3'b1_01;
            10'h154: r = 3'b1_10;
            10'h2AB: r = 3'b1_11;
            default: r = 3'b0_00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] tmds_decode(input logic [9:0] w);
        logic [7:0] q;
        logic [7:0] d;
        q = w[9] ? ~w[7:0] : w[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

    function automatic logic [3:0] next_offset(input logic [3:0] o);
        return (o >= 4'd9) ? 4'd0 : o + 4'd1;
    endfunction

    assign window_s   = {tmds_in, prev_q};
    assign tok_info_s = token_lookup(word_s);
    assign is_tok_s   = tok_info_s[2];
    assign tok_code_s = tok_info_s[1:0];

    // Barrel select of the aligned word out of the two-word window.
    always_comb begin
        word_s = window_s[9:0];
        case (off_q)
            4'd0:    word_s = window_s[9:0];
            4'd1:    word_s = window_s[10:1];
            4'd2:    word_s = window_s[11:2];
            4'd3:    word_s = window_s[12:3];
            4'd4:    word_s = window_s[13:4];
            4'd5:    word_s = window_s[14:5];
            4'd6:    word_s = window_s[15:6];
            4'd7:    word_s = window_s[16:7];
            4'd8:    word_s = window_s[17:8];
            4'd9:    word_s = window_s[18:9];
            default: word_s = window_s[9:0];
        endcase
    end

    // Alignment FSM next-state; every counter advances on accepted words only.
    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        srch_d  = srch_q;
        tok_d   = tok_q;
        loss_d  = loss_q;
        prev_d  = prev_q;
        if (tmds_valid) begin
            prev_d = tmds_in;
            case (state_q)
                ST_SEARCH: begin
                    if (is_tok_s) begin
                        state_d = ST_CHECK;
                        tok_d   = TW'(1);
                        srch_d  = '0;
                    end else if (srch_q == SW'(SEARCH_TIMEOUT - 1)) begin
                        off_d  = next_offset(off_q);
                        srch_d = '0;
                    end else begin
                        srch_d = srch_q + SW'(1);
                    end
                end
                ST_CHECK: begin
                    if (is_tok_s) begin
                        if (tok_q == TW'(LOCK_COUNT - 1)) begin
                            state_d = ST_LOCKED;
                            tok_d   = '0;
                            loss_d  = '0;
                        end else begin
                            tok_d = tok_q + TW'(1);
                        end
                    end else begin
                        state_d = ST_SEARCH;
                        off_d   = next_offset(off_q);
                        srch_d  = '0;
                        tok_d   = '0;
                        loss_d  = '0;
                    end
                end
                ST_LOCKED: begin
                    if (is_tok_s) begin
                        loss_d = '0;
                    end else if (loss_q == LW'(LOSS_TIMEOUT - 1)) begin
                        state_d = ST_SEARCH;
                        srch_d  = '0;
                        tok_d   = '0;
                        loss_d  = '0;
                    end else begin
                        loss_d = loss_q + LW'(1);
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                    srch_d  = '0;
                    tok_d   = '0;
                    loss_d  = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output stage: outputs are zero whenever the next cycle is not aligned,
    // so vd/cd/vde never show stale data alongside aligned=0.
    always_comb begin
        vd_d      = vd_q;
        cd_d      = cd_q;
        vde_d     = vde_q;
        ov_d      = 1'b0;
        aligned_d = (state_d == ST_LOCKED);
        if (state_d != ST_LOCKED) begin
            vd_d  = 8'd0;
            cd_d  = 2'd0;
            vde_d = 1'b0;
        end else if (tmds_valid && (state_q == ST_LOCKED)) begin
            ov_d = 1'b1;
            if (is_tok_s) begin
                vde_d = 1'b0;
                cd_d  = tok_code_s;
                vd_d  = 8'd0;
            end else begin
                vde_d = 1'b1;
                vd_d  = tmds_decode(word_s);
            end
        end else begin
            ov_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_SEARCH;
            off_q     <= 4'd0;
            srch_q    <= '0;
            tok_q     <= '0;
            loss_q    <= '0;
            prev_q    <= 10'd0;
            vd_q      <= 8'd0;
            cd_q      <= 2'd0;
            vde_q     <= 1'b0;
            ov_q      <= 1'b0;
            aligned_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            off_q     <= off_d;
            srch_q    <= srch_d;
            tok_q     <= tok_d;
            loss_q    <= loss_d;
            prev_q    <= prev_d;
            vd_q      <= vd_d;
            cd_q      <= cd_d;
            vde_q     <= vde_d;
            ov_q      <= ov_d;
            aligned_q <= aligned_d;
        end
    end

    assign vd         = vd_q;
    assign cd         = cd_q;
    assign vde        = vde_q;
    assign out_valid  = ov_q;
    assign aligned    = aligned_q;
    assign bit_offset = off_q;

`ifdef TMDS_DECODER_ERRCNT_EN
    logic [15:0] err_q, err_d;
    logic        lost_s;

    assign lost_s = tmds_valid && (state_q == ST_LOCKED) && (state_d == ST_SEARCH);

    // Saturating count of lock-loss events.
    always_comb begin
        if (lost_s && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end else begin
            err_d = err_q;
        end
    end

    // Unlock counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 16'd0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = 16'd0;
`endif

endmodule
